// File: rtl/rambam_reduce_p.sv
// RAMBAM unmasking reducer: bit-serial division of a redundant (8+D)-bit
// value by the degree-8 polynomial P, yielding canonical remainder and quotient.
module rambam_reduce_p #(
    parameter int         D = 4,
    parameter logic [0:8] P = 9'b1_0001_1011
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:7+D] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:7]   out_data,
    output logic [0:D-1] out_q
);

    localparam int CW = $clog2(D) + 1;
    localparam int W  = 8 + D;

    if (D < 1) begin : g_bad_d
        $error("rambam_reduce_p: D must be at least 1");
    end
    if (P[0] != 1'b1) begin : g_bad_p
        $error("rambam_reduce_p: P must have its x^8 coefficient set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [0:W-1]  rem_q, rem_d;
    logic [0:W-1]  pmask;
    logic [0:D-1]  q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:7]    dat_q, dat_d;
    logic [0:D-1]  oq_q, oq_d;
    logic          lead;

    // State and datapath registers; reset clears everything and drops any word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            dat_q   <= '0;
            oq_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            oq_q    <= oq_d;
        end
    end

    // Next-state: one quotient bit per RUN cycle, always D cycles (constant time)
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        oq_d    = oq_q;
        lead    = 1'b0;
        pmask   = '0;
        pmask[0:8] = P;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    rem_d   = in_data;
                    q_d     = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int j = 0; j < D; j++) begin
                    if (cnt_q == CW'(j)) begin
                        lead   = rem_q[j];
                        q_d[j] = rem_q[j];
                    end
                end
                if (lead) begin
                    rem_d = rem_q ^ (pmask >> cnt_q);
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(D - 1)) begin
                    state_d = S_DONE;
                    dat_d   = rem_d[D +: 8];
                    oq_d    = q_d;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = dat_q;
    assign out_q     = oq_q;

endmodule

// File: tb/tb_rambam_reduce_p.sv
// Self-checking bench for rambam_reduce_p (D=4, P=0x11B): directed cases,
// back-to-back throughput, mid-run reset and a randomized round trip.
module tb_rambam_reduce_p;

    localparam int         D = 4;
    localparam logic [0:8] P = 9'b1_0001_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [0:11] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [0:7]  out_data;
    logic [0:3]  out_q;

    int passed = 0;
    int total  = 0;

    rambam_reduce_p #(.D(D), .P(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_q     (out_q)
    );

    always #5 clk = ~clk;

    // Carry-less product r*P as a plain 12-bit integer polynomial
    function automatic logic [11:0] clmul(input logic [3:0] r);
        logic [11:0] acc;
        logic [8:0]  pn;
        acc = '0;
        pn  = P;
        for (int i = 0; i < 4; i++) begin
            if (r[i]) acc = acc ^ ({3'b000, pn} << i);
        end
        return acc;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; leaves us at the negedge after the accept edge
    task automatic accept(input logic [11:0] v);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) chk("accept_timeout", 32'(n), 0);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 30) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic txn(input string tag, input logic [11:0] v,
                       input logic [7:0] ed, input logic [3:0] eq,
                       input int hold);
        int n;
        accept(v);
        wait_out(n);
        chk({tag, "_lat"}, 32'(n), 4);
        chk({tag, "_data"}, 32'(out_data), 32'(ed));
        chk({tag, "_q"}, 32'(out_q), 32'(eq));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 12'($urandom);
            @(negedge clk);
            chk({tag, "_hold"}, {18'd0, out_valid, in_ready, out_data, out_q},
                {18'd0, 1'b1, 1'b0, ed, eq});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ack"}, {30'd0, out_valid, in_ready}, {30'd0, 2'b01});
    endtask

    initial begin : main
        logic [7:0]  b;
        logic [3:0]  r;
        logic [11:0] v;
        logic [11:0] expq[$];
        int          n;
        int          cyc;
        int          last;
        int          nres;
        int          stall;
        int          seen;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset", {20'd0, in_ready, out_valid, out_data, out_q},
            {20'd0, 1'b1, 1'b0, 8'h00, 4'h0});

        // Directed division cases
        txn("r1", 12'h148, 8'h53, 4'b0001, 0);
        txn("r8", 12'h88B, 8'h53, 4'b1000, 0);
        txn("rF", 12'hFCA, 8'h53, 4'b1111, 5);
        txn("r0", 12'h053, 8'h53, 4'b0000, 0);

        // Back-to-back with out_ready tied high; junk data while busy
        out_ready = 1'b1;
        cyc  = 0;
        last = -1;
        nres = 0;
        while (cyc < 60) begin
            if (out_valid === 1'b1) begin
                v = expq.pop_front();
                chk("b2b_data", {20'd0, out_data, out_q}, {20'd0, v[7:0], v[11:8]});
                if (last >= 0) chk("b2b_gap", 32'(cyc - last), 6);
                last = cyc;
                nres++;
            end
            if (cyc < 48) begin
                in_valid = 1'b1;
                if (in_ready === 1'b1) begin
                    b = 8'($urandom);
                    r = 4'($urandom);
                    in_data = {4'b0000, b} ^ clmul(r);
                    expq.push_back({r, b});
                end else begin
                    in_data = 12'($urandom);
                end
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("b2b_count", 32'(nres), 8);
        chk("b2b_drain", 32'(expq.size()), 0);

        // Reset during the second RUN cycle discards the word
        accept(12'h148);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst", {20'd0, in_ready, out_valid, out_data, out_q},
            {20'd0, 1'b1, 1'b0, 8'h00, 4'h0});
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        chk("midrst_noout", 32'(seen), 0);
        txn("post", 12'h88B, 8'h53, 4'b1000, 0);

        // Randomized round trip with random consumer stalls
        for (int k = 0; k < 3000; k++) begin
            b = 8'($urandom);
            r = 4'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            accept({4'b0000, b} ^ clmul(r));
            wait_out(n);
            chk("rt", {12'd0, 8'(n), out_data, out_q}, {12'd0, 8'd4, b, r});
            if (out_ready !== 1'b1) begin
                stall = $urandom_range(0, 2);
                repeat (stall) @(negedge clk);
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
